// File: rtl/sirv_qspi_shifter.sv
// Byte-wide SPI/QSPI frame shifter: serialises one byte per frame over 1/2/4 lanes
// and returns the byte captured on the receive lanes.
module sirv_qspi_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_tx_valid,
  output logic        io_tx_ready,
  input  logic [7:0]  io_tx_bits,
  input  logic [7:0]  io_cnt,
  input  logic [1:0]  io_fmt_proto,
  input  logic        io_fmt_endian,
  input  logic        io_fmt_iodir,
  input  logic [11:0] io_sck_div,
  input  logic        io_sck_pol,
  output logic        io_rx_valid,
  output logic [7:0]  io_rx_bits,
  output logic        io_active,
  output logic        io_sck,
  output logic [3:0]  io_dq_o,
  output logic [3:0]  io_dq_oe,
  input  logic [3:0]  io_dq_i
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic [3:0]  beats;
  logic [11:0] phase;
  logic [11:0] div_q;
  logic [1:0]  proto_q;
  logic        endian_q;
  logic        iodir_q;
  logic        trail;
  logic [3:0]  samp;
  logic [7:0]  tx_next;
  logic [7:0]  rx_next;
  logic [3:0]  cnt_clamped;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  assign cnt_clamped = (io_cnt > 8'd8) ? 4'd8 : io_cnt[3:0];
  assign io_tx_ready = (state == IDLE);
  assign io_active   = (state != IDLE);

  // Proto 3 falls through to the single-lane arm everywhere.
  always_comb begin
    case (proto_q)
      2'd1:    begin tx_next = {tx_sr[5:0], 2'b00};   rx_next = {rx_sr[5:0], samp[1:0]}; end
      2'd2:    begin tx_next = {tx_sr[3:0], 4'b0000}; rx_next = {rx_sr[3:0], samp};      end
      default: begin tx_next = {tx_sr[6:0], 1'b0};    rx_next = {rx_sr[6:0], samp[0]};   end
    endcase
  end

  always_comb begin
    io_dq_o = 4'b0000;
    case (proto_q)
      2'd1:    io_dq_o[1:0] = tx_sr[7:6];
      2'd2:    io_dq_o      = tx_sr[7:4];
      default: io_dq_o[0]   = tx_sr[7];
    endcase
  end

  always_comb begin
    io_dq_oe = 4'b0000;
    if (state == SHIFT) begin
      case (proto_q)
        2'd1:    io_dq_oe = iodir_q ? 4'b0011 : 4'b0000;
        2'd2:    io_dq_oe = iodir_q ? 4'b1111 : 4'b0000;
        default: io_dq_oe = 4'b0001;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_sr       <= 8'h00;
      rx_sr       <= 8'h00;
      beats       <= 4'd0;
      phase       <= 12'd0;
      div_q       <= 12'd0;
      proto_q     <= 2'd0;
      endian_q    <= 1'b0;
      iodir_q     <= 1'b0;
      trail       <= 1'b0;
      samp        <= 4'd0;
      io_sck      <= 1'b0;
      io_rx_valid <= 1'b0;
      io_rx_bits  <= 8'h00;
    end else begin
      io_rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (io_tx_valid) begin
            div_q    <= io_sck_div;
            proto_q  <= io_fmt_proto;
            endian_q <= io_fmt_endian;
            iodir_q  <= io_fmt_iodir;
            io_sck   <= io_sck_pol;
            tx_sr    <= io_fmt_endian ? rev8(io_tx_bits) : io_tx_bits;
            rx_sr    <= 8'h00;
            beats    <= cnt_clamped;
            phase    <= 12'd0;
            trail    <= 1'b0;
            if (cnt_clamped == 4'd0) begin
              state       <= DONE;
              io_rx_valid <= 1'b1;
              io_rx_bits  <= 8'h00;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (phase == div_q) begin
            phase  <= 12'd0;
            io_sck <= ~io_sck;
            trail  <= ~trail;
            if (!trail) begin
              case (proto_q)
                2'd1:    samp <= {2'b00, io_dq_i[1:0]};
                2'd2:    samp <= io_dq_i;
                default: samp <= {3'b000, io_dq_i[1]};
              endcase
            end else begin
              tx_sr <= tx_next;
              rx_sr <= rx_next;
              beats <= beats - 4'd1;
              // Final trailing edge: publish the byte as the frame closes.
              if (beats == 4'd1) begin
                state       <= DONE;
                io_rx_valid <= 1'b1;
                io_rx_bits  <= endian_q ? rev8(rx_next) : rx_next;
              end
            end
          end else begin
            phase <= phase + 12'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_qspi_shifter.sv
// Scoreboard bench for sirv_qspi_shifter: frames are modelled at acceptance and
// matched against rx_valid pulses (byte, cycle, sck toggle count, lane enables).
module tb_sirv_qspi_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_tx_bits;
  logic [7:0]  io_cnt;
  logic [1:0]  io_fmt_proto;
  logic        io_fmt_endian;
  logic        io_fmt_iodir;
  logic [11:0] io_sck_div;
  logic        io_sck_pol;
  logic        io_rx_valid;
  logic [7:0]  io_rx_bits;
  logic        io_active;
  logic        io_sck;
  logic [3:0]  io_dq_o;
  logic [3:0]  io_dq_oe;
  logic [3:0]  io_dq_i;

  logic        loop_en;
  logic [3:0]  fixed_in;

  typedef struct {
    logic [7:0] bits;
    int         cyc;
    int         ntog;
    int         tog0;
    int         oe0;
    logic [1:0] proto;
    logic       iodir;
  } item_t;

  item_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tog = 0;
  int oe_bad = 0;
  logic prev_act = 1'b0;
  logic prev_sck = 1'b0;

  sirv_qspi_shifter dut (
    .clk(clk), .rst_n(rst_n),
    .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready), .io_tx_bits(io_tx_bits),
    .io_cnt(io_cnt), .io_fmt_proto(io_fmt_proto), .io_fmt_endian(io_fmt_endian),
    .io_fmt_iodir(io_fmt_iodir), .io_sck_div(io_sck_div), .io_sck_pol(io_sck_pol),
    .io_rx_valid(io_rx_valid), .io_rx_bits(io_rx_bits), .io_active(io_active),
    .io_sck(io_sck), .io_dq_o(io_dq_o), .io_dq_oe(io_dq_oe), .io_dq_i(io_dq_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign io_dq_i = loop_en ? {2'b00, io_dq_o[0], 1'b0} : fixed_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] tx, input int c, input logic [1:0] pr,
                                       input logic en, input logic lp, input logic [3:0] fx);
    logic [7:0] sr, rx;
    logic [3:0] s;
    int w;
    sr = en ? rev8(tx) : tx;
    rx = 8'h00;
    w  = (pr == 2'd1) ? 2 : (pr == 2'd2) ? 4 : 1;
    for (int i = 0; i < c; i++) begin
      if (lp)            s = {3'b000, sr[7]};
      else if (w == 1)   s = {3'b000, fx[1]};
      else if (w == 2)   s = {2'b00, fx[1:0]};
      else               s = fx;
      rx = (rx << w) | {4'b0000, s};
      sr = sr << w;
    end
    return en ? rev8(rx) : rx;
  endfunction

  function automatic logic [3:0] exp_oe(input logic [1:0] pr, input logic dir);
    if (pr == 2'd1) return dir ? 4'b0011 : 4'b0000;
    if (pr == 2'd2) return dir ? 4'b1111 : 4'b0000;
    return 4'b0001;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act = 1'b0;
    end else begin
      if (io_active && prev_act && io_sck !== prev_sck) tog++;
      if (!io_active && io_dq_oe !== 4'b0000) oe_bad++;
      if (io_active && !io_rx_valid && q.size() > 0)
        if (io_dq_oe !== exp_oe(q[0].proto, q[0].iodir)) oe_bad++;
      if (io_rx_valid) begin
        if (q.size() == 0) begin
          chk("rx_unexpected", 32'd1, 32'd0);
        end else begin
          item_t it;
          it = q.pop_front();
          chk("rx_bits", io_rx_bits, it.bits);
          chk("rx_cycle", cyc, it.cyc);
          chk("sck_toggles", tog - it.tog0, it.ntog);
          chk("dq_oe_frame", oe_bad - it.oe0, 0);
        end
      end
      prev_act = io_active;
    end
    prev_sck = io_sck;
  end

  task automatic send(input logic [7:0] tx, input logic [7:0] c, input logic [1:0] pr,
                      input logic en, input logic dir, input logic [11:0] dv, input logic pl,
                      input logic lp, input logic [3:0] fx, output int t, output logic [7:0] eb);
    item_t it;
    int n = 0;
    int cc;
    @(negedge clk);
    while (!io_tx_ready && n < 300) begin @(negedge clk); n++; end
    if (!io_tx_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      t = -1;
      eb = 8'h00;
      return;
    end
    io_tx_bits = tx; io_cnt = c; io_fmt_proto = pr; io_fmt_endian = en;
    io_fmt_iodir = dir; io_sck_div = dv; io_sck_pol = pl; loop_en = lp; fixed_in = fx;
    io_tx_valid = 1'b1;
    t  = cyc;
    cc = (c > 8'd8) ? 8 : int'(c);
    eb = model(tx, cc, pr, en, lp, fx);
    it.bits = eb; it.cyc = t + 1 + 2 * cc * (int'(dv) + 1); it.ntog = 2 * cc;
    it.tog0 = tog; it.oe0 = oe_bad; it.proto = pr; it.iodir = dir;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || io_active) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2;
    logic [7:0] eb;
    rst_n = 1'b0; io_tx_valid = 1'b0; io_tx_bits = 8'h00; io_cnt = 8'd0;
    io_fmt_proto = 2'd0; io_fmt_endian = 1'b0; io_fmt_iodir = 1'b0;
    io_sck_div = 12'd0; io_sck_pol = 1'b0; loop_en = 1'b0; fixed_in = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_sck", io_sck, 0);
    chk("rst_dq_o", io_dq_o, 0);
    chk("rst_dq_oe", io_dq_oe, 0);
    chk("rst_rx_valid", io_rx_valid, 0);
    chk("rst_rx_bits", io_rx_bits, 0);
    chk("rst_active", io_active, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", io_tx_ready, 1);

    // single loopback, div=0, 8 beats
    send(8'hA5, 8'd8, 2'd0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1, 4'h0, t, eb);
    io_tx_valid = 1'b0;
    drain();

    // quad receive, div=1, 2 beats, fixed 9 on the lanes
    send(8'h3C, 8'd2, 2'd2, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 4'h9, t, eb);
    io_tx_valid = 1'b0;
    drain();

    // LSB-first single: first beat carries the set bit
    send(8'h01, 8'd8, 2'd0, 1'b1, 1'b1, 12'd0, 1'b0, 1'b1, 4'h0, t, eb);
    io_tx_valid = 1'b0;
    @(negedge clk);
    chk("lsb_first_beat0", io_dq_o[0], 1);
    @(negedge clk); @(negedge clk);
    chk("lsb_first_beat1", io_dq_o[0], 0);
    drain();
    repeat (3) @(negedge clk);
    chk("rx_bits_hold", io_rx_bits, eb);

    // cnt=0 with tx_valid held high: second accept two cycles later
    send(8'hFF, 8'd0, 2'd0, 1'b0, 1'b1, 12'd2, 1'b0, 1'b0, 4'hF, t, eb);
    send(8'h77, 8'd0, 2'd0, 1'b0, 1'b1, 12'd2, 1'b0, 1'b0, 4'hF, t2, eb);
    io_tx_valid = 1'b0;
    chk("cnt0_next_accept", t2 - t, 2);
    drain();

    // reset mid-frame aborts with no rx_valid
    send(8'h5A, 8'd8, 2'd0, 1'b0, 1'b1, 12'd3, 1'b1, 1'b1, 4'h0, t, eb);
    io_tx_valid = 1'b0;
    @(negedge clk);
    chk("pol_in_frame", io_sck, 1);
    while (cyc < t + 5) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_sck", io_sck, 0);
    chk("abort_oe", io_dq_oe, 0);
    chk("abort_active", io_active, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'hC3, 8'd8, 2'd0, 1'b0, 1'b1, 12'd1, 1'b0, 1'b1, 4'h0, t, eb);
    io_tx_valid = 1'b0;
    drain();

    // divider change mid-frame only affects the next frame
    send(8'h96, 8'd8, 2'd0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1, 4'h0, t, eb);
    io_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    io_sck_div = 12'd5;
    drain();
    send(8'hE1, 8'd2, 2'd0, 1'b0, 1'b1, 12'd5, 1'b1, 1'b1, 4'h0, t, eb);
    io_tx_valid = 1'b0;
    drain();
    chk("idle_sck_pol", io_sck, 1);

    // dual transmit, cnt clamp above 8
    send(8'h4B, 8'd12, 2'd1, 1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 4'h2, t, eb);
    io_tx_valid = 1'b0;
    drain();

    for (int i = 0; i < 10; i++) begin
      logic [1:0] pr;
      logic lp;
      pr = 2'($urandom_range(0, 3));
      lp = (pr == 2'd0 || pr == 2'd3) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(8'($urandom), 8'($urandom_range(0, 10)), pr, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 12'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
           lp, 4'($urandom), t, eb);
      if ($urandom_range(0, 1) == 0) io_tx_valid = 1'b0;
    end
    io_tx_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
